// File: rtl/shift_result_stage_pkg.sv
// Shared ALU definitions for the shift result stage.
// Widths, gating FSM encoding and the buffered entry layout.
package shift_result_stage_pkg;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef enum logic {
    ACTIVE = 1'b0,
    GATED  = 1'b1
  } gate_state_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic          neg;
    logic          carry;
  } entry_t;

endpackage

// File: rtl/shift_result_stage_flag_gen.sv
// Zero / negative / carry-out flags for a logical shift result.
// Carry is the last bit shifted out of the pre-shift operand.
module shift_flag_gen
  import shift_result_stage_pkg::*;
(
  input  logic [DW-1:0] result,
  input  logic [DW-1:0] src,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  output logic          zero,
  output logic          neg,
  output logic          carry
);

  logic [AW-1:0] idx;

  always_comb begin
    // left: bit DW-amt (wraps to amt's two's complement in AW bits)
    idx   = dir ? (amt - AW'(1)) : (AW'(0) - amt);
    zero  = (result == '0);
    neg   = result[DW-1];
    carry = (amt == '0) ? 1'b0 : src[idx];
  end

endmodule

// File: rtl/shift_result_stage.sv
// Shifter writeback stage: 2-entry result FIFO with flags and
// an idle-driven clock-gate enable for the shifter operands.
module shift_result_stage
  import shift_result_stage_pkg::*;
#(
  parameter int IDLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic [DW-1:0] in_src,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_zero,
  output logic          out_neg,
  output logic          out_carry,
  output logic          gate_en,
  output logic          busy
);

  localparam logic [3:0] IDLE_MAX  = 4'(IDLE_CYCLES);
  localparam logic [3:0] IDLE_LAST = 4'(IDLE_CYCLES - 1);

  gate_state_t state, state_n;
  logic [3:0]  idle, idle_n;
  logic [1:0]  count;
  entry_t      head, tail, fresh;
  logic        push, pop;

  shift_flag_gen u_flags (
    .result (in_result),
    .src    (in_src),
    .amt    (in_amt),
    .dir    (in_dir),
    .zero   (fresh.zero),
    .neg    (fresh.neg),
    .carry  (fresh.carry)
  );

  assign fresh.result = in_result;

  assign gate_en   = (state == ACTIVE);
  assign in_ready  = gate_en && (count != 2'd2) && !rst;
  assign out_valid = (count != 2'd0);
  assign busy      = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = head.result;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign out_carry  = head.carry;

  always_comb begin
    state_n = state;
    idle_n  = idle;
    unique case (state)
      ACTIVE: begin
        if (in_valid || count != 2'd0) begin
          idle_n = '0;
        end else begin
          idle_n = (idle == IDLE_MAX) ? idle : idle + 4'd1;
          if (idle == IDLE_LAST) state_n = GATED;
        end
      end
      GATED: begin
        if (in_valid) begin
          state_n = ACTIVE;
          idle_n  = '0;
        end
      end
      default: begin
        state_n = ACTIVE;
        idle_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACTIVE;
      idle  <= '0;
    end else begin
      state <= state_n;
      idle  <= idle_n;
    end
  end

  // head is the registered output; tail only fills when head is held
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= fresh;
          else               tail <= fresh;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: head <= fresh;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_result_stage.sv
// Directed bench for shift_result_stage: flags, FIFO order,
// clock-gate idle/wake behaviour and reset mid-flight.
module tb_shift_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_result = '0;
  logic [15:0] in_src = '0;
  logic [3:0]  in_amt = '0;
  logic        in_dir = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_zero, out_neg, out_carry;
  logic        gate_en, busy;

  int checks = 0;
  int failures = 0;

  shift_result_stage #(.IDLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_src     (in_src),
    .in_amt     (in_amt),
    .in_dir     (in_dir),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_carry  (out_carry),
    .gate_en    (gate_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [15:0] s, input logic [15:0] r,
                       input logic [3:0] a, input logic d);
    in_src = s;
    in_result = r;
    in_amt = a;
    in_dir = d;
    in_valid = 1'b1;
  endtask

  // {out_valid,busy,gate_en,out_zero,out_neg,out_carry}
  task automatic test_reset;
    logic [5:0] st;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    st = {out_valid, busy, gate_en, out_zero, out_neg, out_carry};
    checks++;
    if (st !== 6'b001000) begin
      failures++;
      $display("FAIL reset_status got=%b want=001000", st);
    end
    checks++;
    if (out_result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_result got=%h want=0000", out_result);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_flags;
    logic [15:0] src [7] = '{16'h8001, 16'h0001, 16'hFFFF, 16'h0003,
                             16'h4000, 16'h8000, 16'h1234};
    logic [3:0]  amt [7] = '{4'd1, 4'd1, 4'd0, 4'd15, 4'd15, 4'd15, 4'd4};
    logic        dir [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] res [7] = '{16'h0002, 16'h0000, 16'hFFFF, 16'h8000,
                             16'h0000, 16'h0001, 16'h2340};
    logic [2:0]  zc  [7] = '{3'b001, 3'b101, 3'b010, 3'b011,
                             3'b101, 3'b000, 3'b001};
    logic [3:0]  got;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(src[i], res[i], amt[i], dir[i]);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL flags_in_ready[%0d] got=%b want=1", i, in_ready);
      end
      tick();
      got = {out_valid, out_zero, out_neg, out_carry};
      checks++;
      if (got !== {1'b1, zc[i]}) begin
        failures++;
        $display("FAIL flags_vzn c[%0d] got=%b want=%b", i, got, {1'b1, zc[i]});
      end
      checks++;
      if (out_result !== res[i]) begin
        failures++;
        $display("FAIL flags_result[%0d] got=%h want=%h", i, out_result, res[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL flags_drain got=%b want=00", {out_valid, busy});
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    drive(16'h0000, 16'hA001, 4'd0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_a_ready got=%b want=1", in_ready);
    end
    tick();
    drive(16'h0000, 16'hB002, 4'd0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_result !== 16'hA001) begin
      failures++;
      $display("FAIL b2b_b_ready got=%b/%h want=1/a001", in_ready, out_result);
    end
    tick();
    drive(16'h0000, 16'hC003, 4'd0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_full got=%b/%b want=0/1", in_ready, busy);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_result !== 16'hA001 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hold got=%b/%h want=0/a001", in_ready, out_result);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_result !== 16'hB002 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pop_b got=%h/%b want=b002/1", out_result, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_result !== 16'hC003 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pop_c got=%h/%b want=c003/1", out_result, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty got=%b/%b want=0/0", out_valid, busy);
    end
  endtask

  task automatic test_gating;
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (gate_en !== (i < 4)) begin
        failures++;
        $display("FAIL gate_idle[%0d] got=%b want=%b", i, gate_en, (i < 4));
      end
    end
    tick();
    tick();
    checks++;
    if (gate_en !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL gate_stay got=%b/%b want=0/0", gate_en, in_ready);
    end
    drive(16'h0001, 16'h8000, 4'd15, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL gate_wake_ready got=%b want=0", in_ready);
    end
    tick();
    checks++;
    if ({gate_en, in_ready, out_valid} !== 3'b110) begin
      failures++;
      $display("FAIL gate_wake got=%b want=110", {gate_en, in_ready, out_valid});
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h8000 || out_neg !== 1'b1) begin
      failures++;
      $display("FAIL gate_accept got=%b/%h want=1/8000", out_valid, out_result);
    end
  endtask

  task automatic test_reset_midflight;
    logic [5:0] st;
    do_reset();
    drive(16'h8001, 16'h8002, 4'd1, 1'b0);
    tick();
    drive(16'hFFFF, 16'hFFFF, 4'd0, 1'b0);
    tick();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_carry !== 1'b1) begin
      failures++;
      $display("FAIL mid_full got=%b/%b/%b want=1/0/1", busy, in_ready, out_carry);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    st = {out_valid, busy, gate_en, out_zero, out_neg, out_carry};
    checks++;
    if (st !== 6'b001000 || out_result !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset got=%b/%h want=001000/0000", st, out_result);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_discard got=%b/%b want=0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_back_to_back();
    test_gating();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_result_stage.md
SHIFT_RESULT_STAGE -- requirements
Module: shift_result_stage

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 4, meaning the number of consecutive idle cycles before the shifter clock-gate enable drops (legal range 2..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  the upstream shifter result is valid.
REQ-005 SHALL have port in_ready  output  1  the stage accepts the beat this cycle.
REQ-006 SHALL have port in_result  input  16  the shifter output word.
REQ-007 SHALL have port in_src  input  16  the pre-shift operand, used for carry.
REQ-008 SHALL have port in_amt  input  4  the shift amount, 0..15.
REQ-009 SHALL have port in_dir  input  1  shift direction, 0 = left, 1 = right (logical).
REQ-010 SHALL have port out_valid  output  1  the head entry is valid.
REQ-011 SHALL have port out_ready  input  1  the downstream consumer takes the head entry.
REQ-012 SHALL have port out_result  output  16  the registered result.
REQ-013 SHALL have port out_zero, out_neg, out_carry  output  1 each  the registered flags.
REQ-014 SHALL have port gate_en  output  1  the clock-gate enable for the shifter operand registers.
REQ-015 SHALL have port busy  output  1  high while the buffer is non-empty.

Function
REQ-016 SHALL store accepted beats in a 2-entry FIFO (count 0..2); a beat is accepted when in_valid && in_ready, and popped when out_valid && out_ready.
REQ-017 SHALL drive in_ready = gate_en && (count != 2); there is no bypass while full, so a simultaneous push and pop at count 2 cannot occur.
REQ-018 SHALL present a beat accepted in cycle N on the outputs in cycle N+1 when the FIFO was empty or popped in cycle N, and otherwise in FIFO order.
REQ-019 SHALL keep out_result and the flags stable while out_valid && !out_ready.
REQ-020 SHALL compute flags at push time:
- zero = (in_result == 0)
- neg = in_result[15]
- carry = 0 if in_amt == 0, in_src[16-in_amt] if left, in_src[in_amt-1] if right
REQ-021 SHALL support simultaneous push and pop at count 1: the count stays 1 and the new beat becomes head.
REQ-022 SHALL implement an FSM with states ACTIVE and GATED, where gate_en = (state == ACTIVE).
REQ-023 SHALL keep an idle counter in ACTIVE that clears on any cycle with in_valid or count != 0 and otherwise increments, saturating at IDLE_CYCLES.
REQ-024 SHALL transition ACTIVE -> GATED on the cycle the idle counter reaches IDLE_CYCLES-1 with in_valid = 0 and count == 0.
REQ-025 SHALL transition GATED -> ACTIVE on the cycle after in_valid is seen high, with in_ready low during GATED, giving a one-cycle wake penalty; the upstream holds in_valid and data per the handshake.
REQ-026 SHALL allow the downstream to pop while GATED only if count != 0, which by REQ-024 cannot occur.
REQ-027 SHALL drive busy = (count != 0).

Reset
REQ-028 SHALL apply reset values when rst is high at a clock edge: state ACTIVE, idle counter 0, count 0, out_valid 0, out_result 0, all flags 0, gate_en 1, busy 0.
REQ-029 SHALL give rst priority over any simultaneous push or pop; reset mid-operation discards buffered entries and in_ready is 0 for that cycle.

Structure
REQ-030 SHALL place the FSM state encoding (ACTIVE, GATED), the data width 16 and the amount width 4 in a shared ALU package.
REQ-031 SHALL implement the carry/zero/neg flag computation as one combinational sub-module named shift_flag_gen.

Verification
REQ-032 SHALL cover this scenario: in_src=16'h8001, amt=1, dir=0, result=16'h0002, out_ready=1 -> next cycle out_result=16'h0002, carry=1, zero=0, neg=0.
REQ-033 SHALL cover this scenario: in_src=16'h0001, amt=1, dir=1, result=0 -> zero=1, carry=1; amt=0, src=16'hFFFF, result=16'hFFFF -> carry=0, neg=1.
REQ-034 SHALL cover this scenario: out_ready=0 with 3 back-to-back beats A, B, C -> A and B accepted, in_ready=0 while C is held; after out_ready=1 the outputs are A, B, C in order with no loss.
REQ-035 SHALL cover this scenario: no traffic after reset, IDLE_CYCLES=4 -> gate_en drops after 4 idle cycles; in_valid then rises -> gate_en=1 next cycle, beat accepted the cycle after.
REQ-036 SHALL cover this scenario: rst asserted with count=2 and out_ready=0 -> next cycle out_valid=0, busy=0, gate_en=1, flags=0.
REQ-037 SHALL cover this scenario: at count=1, push and pop in the same cycle -> count stays 1 and the new beat appears at the head.
